aud_btm_tx: RTL and testbench



---
 rtl/aud_pkg.sv | 40 ++++
 rtl/aud_tx_fifo.sv | 44 ++++
 rtl/aud_btm_tx.sv | 125 ++++++++++++
 tb/tb_aud_btm_tx.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// aud_pkg: shared constants for the AUD branch-trace transmitter.
//   - header mode codes (number of address nibbles = 1 << mode)
//   - idle/sync nibble and header prefix
//   - FSM state encoding
//   - helpers for mode selection and last-nibble index
package aud_pkg;

   localparam logic [1:0] AUD_MODE_4  = 2'd0;
   localparam logic [1:0] AUD_MODE_8  = 2'd1;
   localparam logic [1:0] AUD_MODE_16 = 2'd2;
   localparam logic [1:0] AUD_MODE_32 = 2'd3;

   localparam logic [3:0] AUD_SYNC_IDLE = 4'b0011;
   localparam logic [1:0] AUD_HDR_PFX   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } aud_state_e;

   // Smallest mode whose nibbles cover every changed address bit.
   function automatic logic [1:0] aud_mode_sel(input logic [31:0] diff);
      if (diff[31:16] != 16'h0)     return AUD_MODE_32;
      else if (diff[15:8] != 8'h0)  return AUD_MODE_16;
      else if (diff[7:4] != 4'h0)   return AUD_MODE_8;
      else                          return AUD_MODE_4;
   endfunction

   // Index of the final nibble of a frame: (1 << mode) - 1.
   function automatic logic [2:0] aud_last_nib(input logic [1:0] mode);
      case (mode)
         AUD_MODE_4:  return 3'd0;
         AUD_MODE_8:  return 3'd1;
         AUD_MODE_16: return 3'd3;
         default:     return 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/aud_tx_fifo.sv
// aud_tx_fifo: small FIFO of 32-bit branch addresses.
//   aud_ck, rst_n : clock, async active-low reset
//   push, wr_data : write (ignored when full)
//   pop           : read-advance (ignored when empty)
//   rd_data       : head entry (show-ahead)
//   full, empty   : occupancy flags
module aud_tx_fifo #(
   parameter int FIFO_AW = 2
) (
   input  logic        aud_ck,
   input  logic        rst_n,
   input  logic        push,
   input  logic [31:0] wr_data,
   input  logic        pop,
   output logic [31:0] rd_data,
   output logic        full,
   output logic        empty
);

   logic [31:0]      mem [0:(1<<FIFO_AW)-1];
   // One extra pointer bit distinguishes full from empty.
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge aud_ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge aud_ck) begin
      if (push && !full) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/aud_btm_tx.sv
// aud_btm_tx: transmit side of the AUD branch-trace link.
// Buffers branch targets and serialises each as a header nibble
// {2'b10, mode} followed by 1<<mode address nibbles, LSB nibble first.
//   aud_ck    : link clock (far end samples on negedge)
//   rst_n     : async active-low reset
//   br_addr   : branch target address
//   br_valid  : one-cycle strobe per address, no backpressure
//   ovf_clr   : clears ovf
//   aud_data  : nibble bus (0011 when idle)
//   aud_nsync : 1 on idle/header cycles, 0 on address nibbles
//   busy      : frame on the bus or addresses queued
//   ovf       : sticky, a branch was dropped on a full FIFO
// Build option AUD_BTM_TX_COMPRESS_EN: when defined, only the low nibbles
// that changed since the previous frame are sent; otherwise every frame
// carries all 8 nibbles.
module aud_btm_tx
   import aud_pkg::*;
#(
   parameter int FIFO_AW = 2
) (
   input  logic        aud_ck,
   input  logic        rst_n,
   input  logic [31:0] br_addr,
   input  logic        br_valid,
   input  logic        ovf_clr,
   output logic [3:0]  aud_data,
   output logic        aud_nsync,
   output logic        busy,
   output logic        ovf
);

   aud_state_e  state;
   logic [31:0] cur_addr;
   logic [31:0] last_addr;
   logic [1:0]  mode;
   logic [2:0]  cnt;

   logic        full, empty, push, pop, last_nib;
   logic [31:0] head;
   logic [1:0]  nxt_mode;

   // Fullness is judged before any same-cycle pop, so a full FIFO drops.
   assign push     = br_valid && !full;
   assign last_nib = (cnt == aud_last_nib(mode));
   assign pop      = !empty && ((state == ST_IDLE) ||
                                (state == ST_DATA && last_nib));

`ifdef AUD_BTM_TX_COMPRESS_EN
   // Compare against what the far end will hold when the new frame starts:
   // last_addr from IDLE, or the frame just finishing when back-to-back.
   assign nxt_mode = aud_mode_sel(head ^ ((state == ST_IDLE) ? last_addr : cur_addr));
`else
   assign nxt_mode = AUD_MODE_32;
   logic unused_last;
   assign unused_last = ^last_addr;
`endif

   aud_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .aud_ck  (aud_ck),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (br_addr),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge aud_ck or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cur_addr  <= '0;
         last_addr <= '0;
         mode      <= AUD_MODE_4;
         cnt       <= '0;
         aud_data  <= AUD_SYNC_IDLE;
         aud_nsync <= 1'b1;
         busy      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (br_valid && full) ovf <= 1'b1;
         else if (ovf_clr)     ovf <= 1'b0;

         // Outputs reflect the state held at this edge, so the bus
         // trails the FSM by one cycle.
         case (state)
            ST_IDLE: begin
               aud_nsync <= 1'b1;
               aud_data  <= AUD_SYNC_IDLE;
               busy      <= !empty || push;
               if (!empty) begin
                  cur_addr <= head;
                  mode     <= nxt_mode;
                  state    <= ST_HDR;
               end
            end
            ST_HDR: begin
               aud_nsync <= 1'b1;
               aud_data  <= {AUD_HDR_PFX, mode};
               busy      <= 1'b1;
               cnt       <= '0;
               state     <= ST_DATA;
            end
            ST_DATA: begin
               aud_nsync <= 1'b0;
               aud_data  <= cur_addr[{cnt, 2'b00} +: 4];
               busy      <= 1'b1;
               cnt       <= cnt + 3'd1;
               if (last_nib) begin
                  last_addr <= cur_addr;
                  if (!empty) begin
                     cur_addr <= head;
                     mode     <= nxt_mode;
                     state    <= ST_HDR;
                  end else begin
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aud_btm_tx.sv
module tb_aud_btm_tx;

   logic        aud_ck = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] br_addr = '0;
   logic        br_valid = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [3:0]  aud_data;
   logic        aud_nsync;
   logic        busy;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

   aud_btm_tx #(.FIFO_AW(2)) dut (
      .aud_ck    (aud_ck),
      .rst_n     (rst_n),
      .br_addr   (br_addr),
      .br_valid  (br_valid),
      .ovf_clr   (ovf_clr),
      .aud_data  (aud_data),
      .aud_nsync (aud_nsync),
      .busy      (busy),
      .ovf       (ovf)
   );

   always #5 aud_ck = ~aud_ck;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  hdr;
      logic [31:0] nibs;
      int          n;
      int          gap;
   } frame_t;

   // ---------------- bus monitor: frames as the far end sees them ----------
   frame_t capq[$];
   frame_t cur;
   bit     inf = 0;
   int     gap = 0;

   always @(negedge aud_ck) begin
      if (!rst_n) begin
         inf = 0;
         gap = 0;
      end else if (!aud_nsync) begin
         if (inf) begin
            if (cur.n < 8) cur.nibs = cur.nibs | ({28'h0, aud_data} << (cur.n * 4));
            cur.n++;
         end
      end else begin
         if (inf) begin
            capq.push_back(cur);
            inf = 0;
         end
         if (aud_data[3:2] == 2'b10) begin
            cur.hdr  = aud_data;
            cur.nibs = '0;
            cur.n    = 0;
            cur.gap  = gap;
            gap      = 0;
            inf      = 1;
         end else begin
            gap++;
         end
      end
   end

   // ---------------- reference model ---------------------------------------
   logic [31:0] m_last = '0;

   function automatic frame_t model_frame(input logic [31:0] a);
      frame_t      e;
      logic [31:0] d;
      int          md;
      d = a ^ m_last;
`ifdef AUD_BTM_TX_COMPRESS_EN
      if (d >= 32'h0001_0000)   md = 3;
      else if (d >= 32'h100)    md = 2;
      else if (d >= 32'h10)     md = 1;
      else                      md = 0;
`else
      md = 3;
`endif
      e.n    = 1 << md;
      e.hdr  = 4'b1000 | 4'(md);
      e.nibs = (e.n == 8) ? a : (a & ((32'h1 << (4 * e.n)) - 32'h1));
      e.gap  = 0;
      m_last = a;
      return e;
   endfunction

   // ---------------- stimulus helpers (no checking) ------------------------
   task automatic drive_branch(input logic [31:0] a);
      br_addr  = a;
      br_valid = 1'b1;
      @(negedge aud_ck);
      br_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge aud_ck);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      repeat (3) @(negedge aud_ck);
   endtask

   // ---------------- tests --------------------------------------------------
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge aud_ck);
      n_tests++;
      if ({aud_nsync, aud_data, busy, ovf} !== 7'b1_0011_0_0) begin
         n_fail++;
         $display("FAIL reset_held: got nsync=%b data=%b busy=%b ovf=%b want 1 0011 0 0",
                  aud_nsync, aud_data, busy, ovf);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge aud_ck);
         n_tests++;
         if ({aud_nsync, aud_data, busy, ovf} !== 7'b1_0011_0_0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got nsync=%b data=%b busy=%b ovf=%b want 1 0011 0 0",
                     i, aud_nsync, aud_data, busy, ovf);
         end
      end
   endtask

   task automatic test_single;
      bit          ok;
      frame_t      f;
      logic [3:0]  exp_hdr;
      int          exp_n;
`ifdef AUD_BTM_TX_COMPRESS_EN
      exp_hdr = 4'b1000; exp_n = 1;
`else
      exp_hdr = 4'b1011; exp_n = 8;
`endif
      drive_branch(32'h0000_0005);          // edge t has passed
      @(negedge aud_ck);                    // after t+1
      n_tests++;
      if ({aud_nsync, aud_data} !== 5'b1_0011) begin
         n_fail++;
         $display("FAIL single_t1_idle: got nsync=%b data=%b want 1 0011", aud_nsync, aud_data);
      end
      @(negedge aud_ck);                    // after t+2
      n_tests++;
      if ({aud_nsync, aud_data} !== {1'b1, exp_hdr}) begin
         n_fail++;
         $display("FAIL single_hdr_latency: got nsync=%b data=%b want 1 %b", aud_nsync, aud_data, exp_hdr);
      end
      @(negedge aud_ck);                    // after t+3
      n_tests++;
      if ({aud_nsync, aud_data} !== 5'b0_0101 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_nib0: got nsync=%b data=%b busy=%b want 0 0101 1", aud_nsync, aud_data, busy);
      end
`ifdef AUD_BTM_TX_COMPRESS_EN
      @(negedge aud_ck);
      n_tests++;
      if ({aud_nsync, aud_data, busy} !== 6'b1_0011_0) begin
         n_fail++;
         $display("FAIL single_back_idle: got nsync=%b data=%b busy=%b want 1 0011 0", aud_nsync, aud_data, busy);
      end
`endif
      wait_idle(ok);
      n_tests++;
      if (!ok || capq.size() != 1) begin
         n_fail++;
         $display("FAIL single_frames: got idle=%0d frames=%0d want 1 1", ok, capq.size());
      end else begin
         f = capq.pop_front();
         n_tests++;
         if (f.hdr !== exp_hdr || f.n != exp_n || f.nibs !== 32'h5) begin
            n_fail++;
            $display("FAIL single_frame: got hdr=%b n=%0d nibs=%h want %b %0d 00000005",
                     f.hdr, f.n, f.nibs, exp_hdr, exp_n);
         end
      end
      capq.delete();
      m_last = 32'h5;
   endtask

   task automatic test_directed;
      bit          ok;
      frame_t      f;
      logic [31:0] addrs [3];
      logic [3:0]  ehdr  [3];
      int          en    [3];
      logic [31:0] enib  [3];
      addrs[0] = 32'h1234_5678; addrs[1] = 32'h1234_56A8; addrs[2] = 32'h1234_56A8;
`ifdef AUD_BTM_TX_COMPRESS_EN
      ehdr[0] = 4'b1011; ehdr[1] = 4'b1001; ehdr[2] = 4'b1000;
      en[0] = 8; en[1] = 2; en[2] = 1;
      enib[0] = 32'h1234_5678; enib[1] = 32'hA8; enib[2] = 32'h8;
`else
      for (int i = 0; i < 3; i++) begin
         ehdr[i] = 4'b1011; en[i] = 8; enib[i] = addrs[i];
      end
`endif
      for (int i = 0; i < 3; i++) begin
         drive_branch(addrs[i]);
         wait_idle(ok);
         n_tests++;
         if (!ok || capq.size() != 1) begin
            n_fail++;
            $display("FAIL directed_frames[%0d]: got idle=%0d frames=%0d want 1 1", i, ok, capq.size());
         end else begin
            f = capq.pop_front();
            n_tests++;
            if (f.hdr !== ehdr[i] || f.n != en[i] || f.nibs !== enib[i]) begin
               n_fail++;
               $display("FAIL directed_frame[%0d]: got hdr=%b n=%0d nibs=%h want %b %0d %h",
                        i, f.hdr, f.n, f.nibs, ehdr[i], en[i], enib[i]);
            end
         end
         capq.delete();
      end
      m_last = 32'h1234_56A8;
   endtask

   task automatic test_back_to_back;
      bit          ok;
      frame_t      f, e;
      frame_t      exp_q[$];
      logic [31:0] a;
      logic [31:0] b [5];
      a = m_last ^ 32'hF000_0000;
      for (int k = 0; k < 5; k++) b[k] = $urandom;
      exp_q.push_back(model_frame(a));
      for (int k = 0; k < 4; k++) exp_q.push_back(model_frame(b[k]));   // 5th dropped
      drive_branch(a);                       // after t
      repeat (2) @(negedge aud_ck);          // after t+2: header on the bus
      br_valid = 1'b1;
      br_addr  = b[0];
      for (int k = 1; k < 5; k++) begin
         @(negedge aud_ck);
         br_addr = b[k];
      end
      @(negedge aud_ck);                     // pushes at t+3..t+7
      br_valid = 1'b0;
      n_tests++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: got %b want 1", ovf);
      end
      wait_idle(ok);
      n_tests++;
      if (!ok || capq.size() != 5) begin
         n_fail++;
         $display("FAIL b2b_frames: got idle=%0d frames=%0d want 1 5", ok, capq.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            f = capq.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (f.hdr !== e.hdr || f.n != e.n || f.nibs !== e.nibs || (k > 0 && f.gap != 0)) begin
               n_fail++;
               $display("FAIL b2b_frame[%0d]: got hdr=%b n=%0d nibs=%h gap=%0d want %b %0d %h gap0",
                        k, f.hdr, f.n, f.nibs, f.gap, e.hdr, e.n, e.nibs);
            end
         end
      end
      capq.delete();
      n_tests++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %b want 1", ovf);
      end
      ovf_clr = 1'b1;
      @(negedge aud_ck);
      ovf_clr = 1'b0;
      n_tests++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clr: got %b want 0", ovf);
      end
   endtask

   task automatic test_random;
      bit          ok;
      frame_t      f, e;
      frame_t      exp_q[$];
      logic [31:0] g, a;
      int          k;
      g = m_last;
      for (int it = 0; it < 25; it++) begin
         k = $urandom_range(1, 4);           // at most 4 in flight: never drops
         for (int j = 0; j < k; j++) begin
            case ($urandom_range(0, 4))
               0:       a = g;
               1:       a = g ^ ($urandom & 32'hF);
               2:       a = g ^ ($urandom & 32'hFF);
               3:       a = g ^ ($urandom & 32'hFFFF);
               default: a = $urandom;
            endcase
            g = a;
            exp_q.push_back(model_frame(a));
            drive_branch(a);
            repeat ($urandom_range(0, 2)) @(negedge aud_ck);
         end
         wait_idle(ok);
         n_tests++;
         if (!ok || capq.size() != exp_q.size() || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_frames[%0d]: got idle=%0d frames=%0d ovf=%b want 1 %0d 0",
                     it, ok, capq.size(), ovf, exp_q.size());
         end
         while (capq.size() > 0 && exp_q.size() > 0) begin
            f = capq.pop_front();
            e = exp_q.pop_front();
            n_tests++;
            if (f.hdr !== e.hdr || f.n != e.n || f.nibs !== e.nibs) begin
               n_fail++;
               $display("FAIL rand_frame[%0d]: got hdr=%b n=%0d nibs=%h want %b %0d %h",
                        it, f.hdr, f.n, f.nibs, e.hdr, e.n, e.nibs);
            end
         end
         capq.delete();
         exp_q.delete();
      end
   endtask

   task automatic test_reset_midframe;
      bit          ok;
      frame_t      f;
      logic [31:0] a;
      logic [3:0]  exp_hdr;
      int          exp_n;
`ifdef AUD_BTM_TX_COMPRESS_EN
      exp_hdr = 4'b1000; exp_n = 1;
`else
      exp_hdr = 4'b1011; exp_n = 8;
`endif
      a = m_last ^ 32'h8000_0000 ^ ($urandom & 32'hFFFF);
      drive_branch(a);
      repeat (5) @(negedge aud_ck);          // 3rd nibble on the bus
      n_tests++;
      if ({aud_nsync, aud_data} !== {1'b0, a[11:8]}) begin
         n_fail++;
         $display("FAIL mid_nib2: got nsync=%b data=%h want 0 %h", aud_nsync, aud_data, a[11:8]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({aud_nsync, aud_data, busy, ovf} !== 7'b1_0011_0_0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got nsync=%b data=%b busy=%b ovf=%b want 1 0011 0 0",
                  aud_nsync, aud_data, busy, ovf);
      end
      repeat (2) @(negedge aud_ck);
      rst_n  = 1'b1;
      m_last = '0;
      n_tests++;
      if (capq.size() != 0) begin
         n_fail++;
         $display("FAIL mid_abandoned: got %0d frames want 0", capq.size());
      end
      capq.delete();
      @(negedge aud_ck);
      drive_branch(32'h5);
      wait_idle(ok);
      n_tests++;
      if (!ok || capq.size() != 1) begin
         n_fail++;
         $display("FAIL mid_after_frames: got idle=%0d frames=%0d want 1 1", ok, capq.size());
      end else begin
         f = capq.pop_front();
         n_tests++;
         if (f.hdr !== exp_hdr || f.n != exp_n || f.nibs !== 32'h5) begin
            n_fail++;
            $display("FAIL mid_after_frame: got hdr=%b n=%0d nibs=%h want %b %0d 00000005",
                     f.hdr, f.n, f.nibs, exp_hdr, exp_n);
         end
      end
      capq.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
